// File: rtl/comms_ctrl_pkg.sv
// Shared definitions for the communications control path.
//   state_e   : sequencer FSM state encoding
//   CmdWDefault : default command code width
//   cnt_width() : width of a down-counter able to hold max(a, b)
package comms_ctrl_pkg;

  localparam int unsigned CmdWDefault = 3;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitAcc  = 3'd2,
    StWaitDone = 3'd3,
    StDelay    = 3'd4,
    StDataAck  = 3'd5,
    StDataWait = 3'd6,
    StError    = 3'd7
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ld_downcounter.sv
// Loadable down-counter with zero flag; saturates at zero.
//   clk, rst    : clock, synchronous active-low reset (count -> 0)
//   load_i      : load load_val_i (wins over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one when non-zero
//   zero_o      : count is zero
module ld_downcounter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cmd_sequencer.sv
// Command sequencer: issues NUM_CMDS consecutive command codes to the command engine,
// waiting for each to complete plus an inter-command delay, then kicks the data engine.
//   clk, rst       : clock, synchronous active-low reset
//   start_in       : sequence request (IDLE only)
//   abort_in       : synchronous abort from any busy state
//   first_cmd      : first command code, captured at start
//   command_1      : current command code
//   start          : command request level, held across the whole command run
//   ready_command  : command engine ready (low while executing)
//   start_datos    : data engine start
//   bussy_e        : data engine busy
//   bussy_m        : sequencer busy (command phase)
//   err            : sticky handshake-timeout flag, cleared by the next start
module cmd_sequencer
  import comms_ctrl_pkg::*;
#(
  parameter int unsigned CMD_W          = CmdWDefault,
  parameter int unsigned NUM_CMDS       = 4,
  parameter int unsigned DELAY_CYCLES   = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = cnt_width(DELAY_CYCLES, TIMEOUT_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             abort_in,
  input  logic [CMD_W-1:0] first_cmd,
  output logic [CMD_W-1:0] command_1,
  output logic             start,
  input  logic             ready_command,
  output logic             start_datos,
  input  logic             bussy_e,
  output logic             bussy_m,
  output logic             err
);

  localparam logic [CMD_W-1:0] LastIdx     = CMD_W'(NUM_CMDS - 1);
  localparam logic [CNT_W-1:0] DelayLoad   = CNT_W'(DELAY_CYCLES);
  localparam logic [CNT_W-1:0] TimeoutLoad = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic [CMD_W-1:0] idx_q, idx_d;
  logic             start_q, start_d;
  logic             start_datos_q, start_datos_d;
  logic             bussy_m_q, bussy_m_d;
  logic             err_q, err_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  // Single counter shared by the inter-command delay and every handshake timeout.
  ld_downcounter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    idx_d         = idx_q;
    start_d       = start_q;
    start_datos_d = start_datos_q;
    bussy_m_d     = bussy_m_q;
    err_d         = err_q;
    cnt_load      = 1'b0;
    cnt_val       = TimeoutLoad;
    cnt_dec       = 1'b0;

    // Abort overrides every other transition; err is left untouched.
    if (abort_in && (state_q != StIdle)) begin
      state_d       = StIdle;
      start_d       = 1'b0;
      start_datos_d = 1'b0;
      bussy_m_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_in) begin
            cmd_d     = first_cmd;
            idx_d     = '0;
            err_d     = 1'b0;
            bussy_m_d = 1'b1;
            state_d   = StIssue;
          end
        end
        StIssue: begin
          start_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = StWaitAcc;
        end
        StWaitAcc: begin
          if (!ready_command) begin
            cnt_load = 1'b1;
            state_d  = StWaitDone;
          end else if (cnt_zero) begin
            state_d = StError;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StWaitDone: begin
          if (ready_command) begin
            cnt_load = 1'b1;
            cnt_val  = DelayLoad;
            state_d  = StDelay;
          end else if (cnt_zero) begin
            state_d = StError;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StDelay: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (idx_q < LastIdx) begin
            idx_d   = idx_q + CMD_W'(1);
            cmd_d   = cmd_q + CMD_W'(1);
            state_d = StIssue;
          end else begin
            // Command phase done: hand over to the data engine.
            start_d       = 1'b0;
            bussy_m_d     = 1'b0;
            start_datos_d = 1'b1;
            cnt_load      = 1'b1;
            state_d       = StDataAck;
          end
        end
        StDataAck: begin
          if (bussy_e) begin
            state_d = StDataWait;
          end else if (cnt_zero) begin
            state_d = StError;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        StDataWait: begin
          if (!bussy_e) begin
            start_datos_d = 1'b0;
            state_d       = StIdle;
          end
        end
        StError: begin
          err_d         = 1'b1;
          start_d       = 1'b0;
          start_datos_d = 1'b0;
          bussy_m_d     = 1'b0;
          state_d       = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      idx_q         <= '0;
      start_q       <= 1'b0;
      start_datos_q <= 1'b0;
      bussy_m_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      idx_q         <= idx_d;
      start_q       <= start_d;
      start_datos_q <= start_datos_d;
      bussy_m_q     <= bussy_m_d;
      err_q         <= err_d;
    end
  end

  assign command_1   = cmd_q;
  assign start       = start_q;
  assign start_datos = start_datos_q;
  assign bussy_m     = bussy_m_q;
  assign err         = err_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer. Each scenario is described by handshake latencies; a timeline of
// per-cycle inputs and expected outputs is built from the sequencer's documented timing,
// then replayed against the DUT cycle by cycle.
module tb_cmd_sequencer;

  localparam int unsigned CW = 3;
  localparam int unsigned NC = 3;
  localparam int unsigned DL = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst, start_in, abort_in, ready_command, bussy_e;
  logic [CW-1:0] first_cmd, command_1;
  logic          start, start_datos, bussy_m, err;

  always #5 clk = ~clk;

  cmd_sequencer #(
    .CMD_W          (CW),
    .NUM_CMDS       (NC),
    .DELAY_CYCLES   (DL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .first_cmd     (first_cmd),
    .command_1     (command_1),
    .start         (start),
    .ready_command (ready_command),
    .start_datos   (start_datos),
    .bussy_e       (bussy_e),
    .bussy_m       (bussy_m),
    .err           (err)
  );

  // ph: 0 idle, 1 issue, 2 wait-accept, 3 wait-done, 4 delay, 5 data-ack, 6 data-wait, 7 error
  typedef struct {
    logic          sin, ab, rdy, be, rstn;
    logic [CW-1:0] fc;
    logic [CW-1:0] cmd;
    logic          st, sd, bm, er;
    bit            busy;
    int            ph, ci;
  } cyc_t;

  cyc_t          tl[$];
  logic [CW-1:0] e_cmd;
  logic          e_st, e_sd, e_bm, e_er;
  int            n_checks = 0, n_fail = 0, scen = 0;

  // Scenario description: latency > TO means the event never comes.
  logic [CW-1:0] s_first;
  int            s_acc[NC], s_dn[NC];
  int            s_dack, s_dwait, s_kill, s_kph, s_kci;

  function automatic logic rb();
    return $urandom_range(0, 1) != 0;
  endfunction

  function automatic int rlat();
    return ($urandom_range(0, 11) == 0) ? int'(TO + 1) : int'($urandom_range(0, TO));
  endfunction

  function automatic cyc_t mk(input int ph, input int ci, input bit busy, input logic rdy,
                              input logic be);
    cyc_t c;
    c.sin  = busy ? rb() : 1'b0;  // start_in while busy must be ignored
    c.ab   = 1'b0;
    c.rstn = 1'b1;
    c.rdy  = rdy;
    c.be   = be;
    c.fc   = CW'($urandom);
    c.cmd  = e_cmd;
    c.st   = e_st;
    c.sd   = e_sd;
    c.bm   = e_bm;
    c.er   = e_er;
    c.busy = busy;
    c.ph   = ph;
    c.ci   = ci;
    return c;
  endfunction

  task automatic build();
    cyc_t c;
    bit   dead;
    int   j;
    dead = 1'b0;
    tl.delete();
    c = mk(0, 0, 1'b0, rb(), rb());
    c.sin = 1'b1;
    c.fc  = s_first;
    tl.push_back(c);
    e_cmd = s_first;
    e_er  = 1'b0;
    e_bm  = 1'b1;
    e_sd  = 1'b0;
    for (int i = 0; i < int'(NC) && !dead; i++) begin
      tl.push_back(mk(1, i, 1'b1, rb(), rb()));
      e_st = 1'b1;
      if (s_acc[i] > int'(TO)) begin
        for (int k = 0; k <= int'(TO); k++) tl.push_back(mk(2, i, 1'b1, 1'b1, rb()));
        dead = 1'b1;
      end else begin
        for (int k = 0; k <= s_acc[i]; k++) tl.push_back(mk(2, i, 1'b1, k != s_acc[i], rb()));
      end
      if (!dead) begin
        if (s_dn[i] > int'(TO)) begin
          for (int k = 0; k <= int'(TO); k++) tl.push_back(mk(3, i, 1'b1, 1'b0, rb()));
          dead = 1'b1;
        end else begin
          for (int k = 0; k <= s_dn[i]; k++) tl.push_back(mk(3, i, 1'b1, k == s_dn[i], rb()));
        end
      end
      if (!dead) begin
        for (int k = 0; k <= int'(DL); k++) tl.push_back(mk(4, i, 1'b1, rb(), rb()));
        if (i < int'(NC) - 1) begin
          e_cmd = e_cmd + 1'b1;
        end else begin
          e_st = 1'b0;
          e_bm = 1'b0;
          e_sd = 1'b1;
        end
      end
    end
    if (!dead) begin
      if (s_dack > int'(TO)) begin
        for (int k = 0; k <= int'(TO); k++) tl.push_back(mk(5, 0, 1'b1, rb(), 1'b0));
        dead = 1'b1;
      end else begin
        for (int k = 0; k <= s_dack; k++) tl.push_back(mk(5, 0, 1'b1, rb(), k == s_dack));
      end
      if (!dead) begin
        for (int k = 0; k <= s_dwait; k++) tl.push_back(mk(6, 0, 1'b1, rb(), k < s_dwait));
        e_sd = 1'b0;
      end
    end
    if (dead) begin
      tl.push_back(mk(7, 0, 1'b1, rb(), rb()));
      e_er = 1'b1;
      e_st = 1'b0;
      e_sd = 1'b0;
      e_bm = 1'b0;
    end
    if (s_kill != 0) begin
      j = -1;
      if (s_kph < 0) begin
        j = int'($urandom_range(1, tl.size() - 1));
      end else begin
        foreach (tl[k]) if (j < 0 && tl[k].ph == s_kph && tl[k].ci == s_kci) j = k;
      end
      if (j > 0) begin
        while (tl.size() > j + 1) void'(tl.pop_back());
        c = tl[j];
        if (s_kill == 1) c.ab = 1'b1;
        else c.rstn = 1'b0;
        tl[j] = c;
        e_cmd = (s_kill == 1) ? c.cmd : '0;
        e_er  = (s_kill == 1) ? c.er : 1'b0;
        e_st  = 1'b0;
        e_sd  = 1'b0;
        e_bm  = 1'b0;
      end
    end
    for (int k = 0; k < 3; k++) begin
      c = mk(0, 0, 1'b0, rb(), rb());
      c.ab = rb();  // abort in idle has no effect
      tl.push_back(c);
    end
  endtask

  task automatic check_bit(input string tag, input int cyc, input logic got, input logic exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s scen=%0d cyc=%0d got=%b exp=%b", tag, scen, cyc, got, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input int cyc, input logic [CW-1:0] got,
                           input logic [CW-1:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s scen=%0d cyc=%0d got=%0d exp=%0d", tag, scen, cyc, got, exp);
    end
  endtask

  task automatic run();
    build();
    foreach (tl[k]) begin
      @(posedge clk);
      #1;
      check_cmd("command_1", k, command_1, tl[k].cmd);
      check_bit("start", k, start, tl[k].st);
      check_bit("start_datos", k, start_datos, tl[k].sd);
      check_bit("bussy_m", k, bussy_m, tl[k].bm);
      check_bit("err", k, err, tl[k].er);
      start_in      = tl[k].sin;
      abort_in      = tl[k].ab;
      rst           = tl[k].rstn;
      ready_command = tl[k].rdy;
      bussy_e       = tl[k].be;
      first_cmd     = tl[k].fc;
    end
    scen++;
  endtask

  task automatic set_lat(input int a, input int d, input int e, input int h);
    for (int i = 0; i < int'(NC); i++) begin
      s_acc[i] = a;
      s_dn[i]  = d;
    end
    s_dack  = e;
    s_dwait = h;
    s_kill  = 0;
    s_kph   = -1;
    s_kci   = 0;
  endtask

  initial begin
    rst = 1'b0; start_in = 1'b0; abort_in = 1'b0; ready_command = 1'b1;
    bussy_e = 1'b0; first_cmd = '0;
    e_cmd = '0; e_st = 1'b0; e_sd = 1'b0; e_bm = 1'b0; e_er = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cmd("reset_command_1", 0, command_1, '0);
    check_bit("reset_start", 0, start, 1'b0);
    check_bit("reset_start_datos", 0, start_datos, 1'b0);
    check_bit("reset_bussy_m", 0, bussy_m, 1'b0);
    check_bit("reset_err", 0, err, 1'b0);
    rst = 1'b1;

    // Nominal run, codes 5,6,7
    s_first = 3'd5; set_lat(1, 3, 0, 2); run();
    // Code wrap 7,0,1
    s_first = 3'd7; set_lat(1, 3, 1, 0); run();
    // ready_command never drops: timeout in first accept wait
    s_first = 3'd2; set_lat(1, 3, 0, 1); s_acc[0] = TO + 1; run();
    // Next start clears err
    s_first = 3'd1; set_lat(0, 0, 0, 0); run();
    // bussy_e never rises: data-ack timeout
    s_first = 3'd4; set_lat(2, 1, TO + 1, 0); run();
    // Completion exactly on the last counted cycle is not a timeout
    s_first = 3'd6; set_lat(TO, TO, TO, 3); run();
    // Done wait timeout on the last command
    s_first = 3'd0; set_lat(0, 2, 0, 0); s_dn[NC-1] = TO + 1; run();
    // Abort during the delay after command 2
    s_first = 3'd3; set_lat(1, 2, 0, 0); s_kill = 1; s_kph = 4; s_kci = 1; run();
    // Reset during a done wait
    s_first = 3'd6; set_lat(1, 4, 0, 0); s_kill = 2; s_kph = 3; s_kci = 0; run();

    for (int n = 0; n < 40; n++) begin
      s_first = CW'($urandom);
      set_lat(0, 0, 0, 0);
      for (int i = 0; i < int'(NC); i++) begin
        s_acc[i] = rlat();
        s_dn[i]  = rlat();
      end
      s_dack  = rlat();
      s_dwait = int'($urandom_range(0, 3));
      s_kill  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
